// File: rtl/uart_hex_entry_rx.sv
// UART receiver feeding an N-digit hex entry buffer with backspace/escape editing.
// Optional even parity: define UART_PARITY_EN.
module uart_hex_entry_rx #(
    parameter int CLK_HZ = 60_000_000,
    parameter int BAUD   = 115_200,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rxd,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  byte_strobe,
    output logic [7:0]            byte_data,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_WAIT_HI = 3'd5;

    logic                 rx_meta;
    logic                 rxs;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bitn;
    logic [7:0]           shreg;
    logic                 is_hex;
    logic [3:0]           nib;
    logic [4*DIGITS-1:0]  nib_ext;
    logic [DIGITS-1:0]    one_lsb;
    logic                 par_ok;
    logic                 bit_tick;

`ifdef UART_PARITY_EN
    logic                 par_bad;
    assign par_ok = !par_bad;
`else
    assign par_ok = 1'b1;
`endif

    assign rx_busy  = (state != S_IDLE);
    assign bit_tick = (cnt == CW'(CPB - 1));

    always_comb begin
        is_hex  = 1'b0;
        nib     = '0;
        nib_ext = '0;
        one_lsb = '0;
        if (shreg >= 8'h30 && shreg <= 8'h39) begin
            is_hex = 1'b1;
            nib    = shreg[3:0];
        end else if ((shreg >= 8'h41 && shreg <= 8'h46) ||
                     (shreg >= 8'h61 && shreg <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = shreg[3:0] + 4'd9;
        end
        nib_ext[3:0] = nib;
        one_lsb[0]   = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            state       <= S_IDLE;
            cnt         <= '0;
            bitn        <= '0;
            shreg       <= '0;
            hex_out     <= '0;
            digit_valid <= '0;
            byte_strobe <= 1'b0;
            byte_data   <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad     <= 1'b0;
`endif
        end else begin
            rx_meta     <= uart_rxd;
            rxs         <= rx_meta;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt  <= '0;
                    bitn <= '0;
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    // Half-bit check rejects short glitches before committing to a frame
                    if (cnt == CW'(HALF - 1)) begin
                        cnt   <= '0;
                        state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        bitn  <= bitn + 1'b1;
                        if (bitn == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        state <= S_STOP;
`ifdef UART_PARITY_EN
                        par_bad <= rxs ^ (^shreg);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_HI;
                        end else begin
                            state <= S_IDLE;
                            if (!par_ok) begin
                                parity_err <= 1'b1;
                            end else begin
                                byte_strobe <= 1'b1;
                                byte_data   <= shreg;
                                if (is_hex) begin
                                    hex_out     <= (hex_out << 4) | nib_ext;
                                    digit_valid <= (digit_valid << 1) | one_lsb;
                                end else if (shreg == 8'h08) begin
                                    if (digit_valid != '0) begin
                                        hex_out     <= hex_out >> 4;
                                        digit_valid <= digit_valid >> 1;
                                    end
                                end else if (shreg == 8'h1B) begin
                                    hex_out     <= '0;
                                    digit_valid <= '0;
                                end
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_entry_rx.sv
// Bench for uart_hex_entry_rx: table vectors, editing corner cases, randomized bytes vs a queue model.
// Honours UART_PARITY_EN the same way as the design.
module tb_uart_hex_entry_rx;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rxd = 1'b1;
    logic [23:0] hex_out;
    logic [5:0]  digit_valid;
    logic        byte_strobe;
    logic [7:0]  byte_data;
    logic        rx_busy;
    logic        frame_err;
    logic        parity_err;

    uart_hex_entry_rx #(
        .CLK_HZ (1_000_000),
        .BAUD   (100_000),
        .DIGITS (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rxd    (uart_rxd),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .byte_strobe (byte_strobe),
        .byte_data   (byte_data),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_strobe = 0;
    int n_ferr = 0;
    int n_perr = 0;
    logic [3:0] q[$];
`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    always @(negedge clk) begin
        if (byte_strobe) n_strobe++;
        if (frame_err)   n_ferr++;
        if (parity_err)  n_perr++;
    end

    typedef struct {
        logic [7:0]  b;
        logic [23:0] hex;
        logic [5:0]  v;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of nibbles, newest at the back
    task automatic model_apply(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) q.push_back(4'(b - 8'h30));
        else if (b >= 8'h41 && b <= 8'h46) q.push_back(4'(b - 8'h37));
        else if (b >= 8'h61 && b <= 8'h66) q.push_back(4'(b - 8'h57));
        else if (b == 8'h08) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (b == 8'h1B) q.delete();
        if (q.size() > 6) void'(q.pop_front());
    endtask

    function automatic logic [23:0] model_hex();
        logic [23:0] h = '0;
        for (int i = 0; i < q.size(); i++)
            h = h | (24'(q[q.size() - 1 - i]) << (4 * i));
        return h;
    endfunction

    function automatic logic [5:0] model_valid();
        return 6'((1 << q.size()) - 1);
    endfunction

    task automatic drive_bit(input logic v);
        uart_rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
        drive_bit((^b) ^ par_flip);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_check(input logic [7:0] b);
        int s0 = n_strobe;
        model_apply(b);
        send_frame(b, 1'b1);
        idle(5);
        chk("strobe_count", 64'(n_strobe - s0), 64'd1);
        chk("byte_data", 64'(byte_data), 64'(b));
        chk("hex_out", 64'(hex_out), 64'(model_hex()));
        chk("digit_valid", 64'(digit_valid), 64'(model_valid()));
    endtask

    initial begin
        int s0, f0, p0, busy;
        logic [23:0] h0;
        logic [7:0] rb;

        tbl[0]  = '{8'h31, 24'h000001, 6'h01};
        tbl[1]  = '{8'h32, 24'h000012, 6'h03};
        tbl[2]  = '{8'h41, 24'h00012A, 6'h07};
        tbl[3]  = '{8'h66, 24'h0012AF, 6'h0F};
        tbl[4]  = '{8'h08, 24'h00012A, 6'h07};
        tbl[5]  = '{8'h1B, 24'h000000, 6'h00};
        tbl[6]  = '{8'h08, 24'h000000, 6'h00};
        tbl[7]  = '{8'h31, 24'h000001, 6'h01};
        tbl[8]  = '{8'h32, 24'h000012, 6'h03};
        tbl[9]  = '{8'h33, 24'h000123, 6'h07};
        tbl[10] = '{8'h34, 24'h001234, 6'h0F};
        tbl[11] = '{8'h35, 24'h012345, 6'h1F};
        tbl[12] = '{8'h36, 24'h123456, 6'h3F};
        tbl[13] = '{8'h37, 24'h234567, 6'h3F};
        tbl[14] = '{8'h47, 24'h234567, 6'h3F};
        tbl[15] = '{8'h61, 24'h34567A, 6'h3F};

        repeat (4) @(negedge clk);
        chk("reset_outputs", 64'({hex_out, digit_valid, byte_data, byte_strobe, rx_busy, frame_err, parity_err}), 64'd0);
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 16; i++) begin
            s0 = n_strobe;
            model_apply(tbl[i].b);
            send_frame(tbl[i].b, 1'b1);
            idle(5);
            chk("tbl_strobe", 64'(n_strobe - s0), 64'd1);
            chk("tbl_byte_data", 64'(byte_data), 64'(tbl[i].b));
            chk("tbl_hex_out", 64'(hex_out), 64'(tbl[i].hex));
            chk("tbl_digit_valid", 64'(digit_valid), 64'(tbl[i].v));
        end

        // 4-cycle glitch on the line
        s0 = n_strobe; f0 = n_ferr; p0 = n_perr; busy = 0;
        uart_rxd = 1'b0;
        repeat (4) begin @(negedge clk); if (rx_busy) busy++; end
        uart_rxd = 1'b1;
        repeat (20) begin @(negedge clk); if (rx_busy) busy++; end
        chk("glitch_busy_seen", 64'(busy > 0), 64'd1);
        chk("glitch_busy_short", 64'(busy <= CPB / 2 + 3), 64'd1);
        chk("glitch_no_strobe", 64'(n_strobe - s0), 64'd0);
        chk("glitch_no_err", 64'((n_ferr - f0) + (n_perr - p0)), 64'd0);
        send_check(8'h35);

        // stop bit low then line held low
        s0 = n_strobe; f0 = n_ferr; p0 = n_perr; h0 = model_hex();
        send_frame(8'h33, 1'b0);
        repeat (30) @(negedge clk);
        chk("ferr_pulse", 64'(n_ferr - f0), 64'd1);
        chk("ferr_no_strobe", 64'(n_strobe - s0), 64'd0);
        chk("ferr_no_perr", 64'(n_perr - p0), 64'd0);
        chk("ferr_hex_kept", 64'(hex_out), 64'(h0));
        chk("ferr_wait_hi_busy", 64'(rx_busy), 64'd1);
        idle(6);
        chk("ferr_released", 64'(rx_busy), 64'd0);
        send_check(8'h62);

        // reset during data bits
        @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midframe_reset", 64'({hex_out, digit_valid, byte_data, byte_strobe, rx_busy, frame_err, parity_err}), 64'd0);
        q.delete();
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        send_check(8'h37);

`ifdef UART_PARITY_EN
        s0 = n_strobe; p0 = n_perr; h0 = model_hex();
        par_flip = 1'b1;
        send_frame(8'h31, 1'b1);
        par_flip = 1'b0;
        idle(5);
        chk("perr_pulse", 64'(n_perr - p0), 64'd1);
        chk("perr_no_strobe", 64'(n_strobe - s0), 64'd0);
        chk("perr_hex_kept", 64'(hex_out), 64'(h0));
        send_check(8'h31);
        chk("par_low_nibble", 64'(hex_out[3:0]), 64'd1);
`endif

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rb = 8'(8'h30 + $urandom_range(0, 9));
                4:          rb = 8'(8'h41 + $urandom_range(0, 5));
                5:          rb = 8'(8'h61 + $urandom_range(0, 5));
                6:          rb = 8'h08;
                7:          rb = ($urandom_range(0, 3) == 0) ? 8'h1B : 8'h08;
                default:    rb = 8'($urandom);
            endcase
            send_check(rb);
        end

`ifndef UART_PARITY_EN
        chk("parity_tied_low", 64'(n_perr), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
